// File: rtl/synth_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_cmd_pkg
// Description : Opcodes and decoder state encoding for the synth command path.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_cmd_pkg;

   localparam logic [7:0] OP_MOD_FCW    = 8'h01;
   localparam logic [7:0] OP_MOD_SHIFT  = 8'h02;
   localparam logic [7:0] OP_NOTE_START = 8'h03;
   localparam logic [7:0] OP_NOTE_STOP  = 8'h04;
   localparam logic [7:0] OP_ALL_OFF    = 8'h05;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EXEC    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/synth_voice_pick.sv
`default_nettype none
// ============================================================================
// Module      : synth_voice_pick
// Description : Combinational voice search: duplicate match, lowest free slot,
//               and oldest active voice (ties resolved to the lowest index).
// Revision    : 1.0 - initial release
// ============================================================================
module synth_voice_pick
   import synth_cmd_pkg::*;
#(
   parameter int N_VOICES = 4,
   parameter int FCW_W    = 24,
   parameter int AGE_W    = 2,
   parameter int IDX_W    = 2
) (
   input  logic [N_VOICES*FCW_W-1:0] i_fcws,
   input  logic [N_VOICES-1:0]       i_note_en,
   input  logic [N_VOICES*AGE_W-1:0] i_ages,
   input  logic [FCW_W-1:0]          i_f,
   output logic                      o_match_hit,
   output logic [IDX_W-1:0]          o_match_idx,
   output logic                      o_free_hit,
   output logic [IDX_W-1:0]          o_free_idx,
   output logic [IDX_W-1:0]          o_oldest_idx
);

   logic [AGE_W-1:0] w_best_age;
   logic             w_found;

   always_comb begin
      o_match_hit  = 1'b0;
      o_match_idx  = '0;
      o_free_hit   = 1'b0;
      o_free_idx   = '0;
      o_oldest_idx = '0;
      w_best_age   = '0;
      w_found      = 1'b0;
      // Scan downward so the last hit written is the lowest index.
      for (int v = N_VOICES - 1; v >= 0; v--) begin
         if (i_note_en[v] && (i_fcws[v*FCW_W +: FCW_W] == i_f)) begin
            o_match_hit = 1'b1;
            o_match_idx = IDX_W'(v);
         end
         if (!i_note_en[v]) begin
            o_free_hit = 1'b1;
            o_free_idx = IDX_W'(v);
         end
      end
      for (int v = 0; v < N_VOICES; v++) begin
         if (i_note_en[v] && (!w_found || (i_ages[v*AGE_W +: AGE_W] > w_best_age))) begin
            w_found      = 1'b1;
            w_best_age   = i_ages[v*AGE_W +: AGE_W];
            o_oldest_idx = IDX_W'(v);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/synth_cmd_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : synth_cmd_voice_alloc
// Description : Host byte-stream command decoder and carrier voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module synth_cmd_voice_alloc
   import synth_cmd_pkg::*;
#(
   parameter int N_VOICES       = 4,
   parameter int FCW_W          = 24,
   parameter int SHIFT_W        = 5,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [FCW_W-1:0]          mod_fcw,
   output logic [SHIFT_W-1:0]        mod_shift,
   output logic [N_VOICES*FCW_W-1:0] carrier_fcws,
   output logic [N_VOICES-1:0]       note_en,
   output logic                      voice_steal,
   output logic                      cmd_error
);

   localparam int c_fcw_bytes = (FCW_W + 7) / 8;
   localparam int c_pay_w     = c_fcw_bytes * 8;
   localparam int c_age_w     = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
   localparam int c_cnt_w     = $clog2(c_fcw_bytes + 1);
   localparam int c_to_w      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_age_w-1:0] c_age_max  = c_age_w'(N_VOICES - 1);
   localparam logic [c_to_w-1:0]  c_tmo_last = c_to_w'(TIMEOUT_CYCLES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [7:0]           r_op;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   w_cnt_last;
   logic [c_pay_w-1:0]   r_pay;
   logic [c_to_w-1:0]    r_tmo;
   logic [FCW_W-1:0]     r_mod_fcw;
   logic [SHIFT_W-1:0]   r_mod_shift;
   logic                 r_steal;
   logic                 r_err;
   logic                 w_ready;
   logic                 w_hs;
   logic                 w_bad_op;
   logic                 w_timeout;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   assign w_cnt_last = (r_op == OP_MOD_SHIFT) ? '0 : c_cnt_w'(c_fcw_bytes - 1);

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_hs        = 1'b0;
      w_bad_op    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            w_hs    = in_valid;
            if (in_valid) begin
               case (in_data)
                  OP_MOD_FCW, OP_MOD_SHIFT, OP_NOTE_START, OP_NOTE_STOP: w_state_nxt = COLLECT;
                  OP_ALL_OFF: w_state_nxt = EXEC;
                  default:    w_bad_op    = 1'b1;
               endcase
            end
         end
         COLLECT: begin
            w_ready = 1'b1;
            w_hs    = in_valid;
            if (in_valid) begin
               if (r_cnt == w_cnt_last) w_state_nxt = EXEC;
            end else if (r_tmo == c_tmo_last) begin
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         EXEC:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Little-endian payload: each new byte enters at the top and shifts down.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op  <= '0;
         r_cnt <= '0;
         r_pay <= '0;
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_bad_op | w_timeout;
         if (r_state == IDLE && w_hs) begin
            r_op  <= in_data;
            r_cnt <= '0;
         end
         if (r_state == COLLECT && w_hs) begin
            r_pay <= {in_data, r_pay[c_pay_w-1:8]};
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == COLLECT && !w_hs) r_tmo <= r_tmo + 1'b1;
         else                             r_tmo <= '0;
      end
   end

   logic                          w_exec;
   logic [FCW_W-1:0]              w_f;
   logic                          w_start;
   logic                          w_stop;
   logic                          w_alloff;
   logic                          w_match_hit;
   logic                          w_free_hit;
   logic [c_age_w-1:0]            w_match_idx;
   logic [c_age_w-1:0]            w_free_idx;
   logic [c_age_w-1:0]            w_oldest_idx;
   logic [c_age_w-1:0]            w_tgt;
   logic                          w_load;
   logic [N_VOICES*FCW_W-1:0]     w_fcws;
   logic [N_VOICES-1:0]           w_en;
   logic [N_VOICES*c_age_w-1:0]   w_ages;

   assign w_exec   = (r_state == EXEC);
   assign w_f      = r_pay[FCW_W-1:0];
   assign w_start  = w_exec && (r_op == OP_NOTE_START);
   assign w_stop   = w_exec && (r_op == OP_NOTE_STOP);
   assign w_alloff = w_exec && (r_op == OP_ALL_OFF);
   assign w_tgt    = w_match_hit ? w_match_idx : (w_free_hit ? w_free_idx : w_oldest_idx);
   assign w_load   = w_start && !w_match_hit;

   synth_voice_pick #(
      .N_VOICES (N_VOICES),
      .FCW_W    (FCW_W),
      .AGE_W    (c_age_w),
      .IDX_W    (c_age_w)
   ) u_pick (
      .i_fcws       (w_fcws),
      .i_note_en    (w_en),
      .i_ages       (w_ages),
      .i_f          (w_f),
      .o_match_hit  (w_match_hit),
      .o_match_idx  (w_match_idx),
      .o_free_hit   (w_free_hit),
      .o_free_idx   (w_free_idx),
      .o_oldest_idx (w_oldest_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mod_fcw   <= '0;
         r_mod_shift <= '0;
         r_steal     <= 1'b0;
      end else begin
         r_steal <= w_start && !w_match_hit && !w_free_hit;
         if (w_exec && r_op == OP_MOD_FCW)   r_mod_fcw   <= w_f;
         if (w_exec && r_op == OP_MOD_SHIFT) r_mod_shift <= r_pay[c_pay_w-8 +: SHIFT_W];
      end
   end

   for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
      logic [FCW_W-1:0]   r_fcw;
      logic               r_en;
      logic [c_age_w-1:0] r_age;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_fcw <= '0;
            r_en  <= 1'b0;
            r_age <= '0;
         end else if (w_alloff) begin
            r_en  <= 1'b0;
            r_age <= '0;
         end else if (w_start) begin
            if (w_tgt == c_age_w'(v)) begin
               r_age <= '0;
               if (w_load) begin
                  r_fcw <= w_f;
                  r_en  <= 1'b1;
               end
            end else if (r_en && r_age != c_age_max) begin
               r_age <= r_age + 1'b1;
            end
         end else if (w_stop && r_en && r_fcw == w_f) begin
            r_en <= 1'b0;
         end
      end

      assign w_fcws[v*FCW_W +: FCW_W]     = r_fcw;
      assign w_en[v]                      = r_en;
      assign w_ages[v*c_age_w +: c_age_w] = r_age;
   end

   assign in_ready     = w_ready;
   assign mod_fcw      = r_mod_fcw;
   assign mod_shift    = r_mod_shift;
   assign carrier_fcws = w_fcws;
   assign note_en      = w_en;
   assign voice_steal  = r_steal;
   assign cmd_error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_synth_cmd_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_synth_cmd_voice_alloc
// Description : Scoreboard bench for the command decoder / voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synth_cmd_voice_alloc;

   localparam int N  = 4;
   localparam int FW = 24;
   localparam int SW = 5;
   localparam int TO = 100;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      in_data;
   logic            in_valid;
   logic            in_ready;
   logic [FW-1:0]   mod_fcw;
   logic [SW-1:0]   mod_shift;
   logic [N*FW-1:0] carrier_fcws;
   logic [N-1:0]    note_en;
   logic            voice_steal;
   logic            cmd_error;

   always #5 clk = ~clk;

   synth_cmd_voice_alloc #(
      .N_VOICES       (N),
      .FCW_W          (FW),
      .SHIFT_W        (SW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mod_fcw      (mod_fcw),
      .mod_shift    (mod_shift),
      .carrier_fcws (carrier_fcws),
      .note_en      (note_en),
      .voice_steal  (voice_steal),
      .cmd_error    (cmd_error)
   );

   typedef struct {
      logic [FW-1:0]   mfcw;
      logic [SW-1:0]   mshift;
      logic [N*FW-1:0] cf;
      logic [N-1:0]    en;
      logic            stl;
      logic            err;
   } snap_t;

   snap_t sb[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    n_steal_pulse = 0;
   int    n_err_pulse = 0;

   logic [FW-1:0] m_mfcw;
   logic [SW-1:0] m_ms;
   logic [FW-1:0] m_f[N];
   logic          m_en[N];
   int            m_age[N];

   always @(negedge clk) begin
      if (voice_steal) n_steal_pulse++;
      if (cmd_error)   n_err_pulse++;
   end

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic m_reset();
      m_mfcw = '0;
      m_ms   = '0;
      for (int v = 0; v < N; v++) begin
         m_f[v] = '0; m_en[v] = 1'b0; m_age[v] = 0;
      end
   endtask

   task automatic m_start(input logic [FW-1:0] f, output bit stl);
      int t = -1;
      bit retrig = 0;
      stl = 0;
      for (int v = 0; v < N; v++)
         if (t < 0 && m_en[v] && m_f[v] == f) begin t = v; retrig = 1; end
      if (t < 0)
         for (int v = 0; v < N; v++)
            if (t < 0 && !m_en[v]) t = v;
      if (t < 0) begin
         stl = 1;
         t   = 0;
         for (int v = 1; v < N; v++)
            if (m_age[v] > m_age[t]) t = v;
      end
      if (!retrig) begin m_f[t] = f; m_en[t] = 1'b1; end
      for (int v = 0; v < N; v++) begin
         if (v == t)                        m_age[v] = 0;
         else if (m_en[v] && m_age[v] < N-1) m_age[v]++;
      end
   endtask

   function automatic snap_t m_snap(input bit stl, input bit err);
      snap_t s;
      s.mfcw   = m_mfcw;
      s.mshift = m_ms;
      for (int v = 0; v < N; v++) begin
         s.cf[v*FW +: FW] = m_f[v];
         s.en[v]          = m_en[v];
      end
      s.stl = stl;
      s.err = err;
      return s;
   endfunction

   task automatic cmp_snap(input string tag);
      snap_t s;
      chk_eq({tag, ".sb_pending"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         s = sb.pop_front();
         chk_eq({tag, ".mod_fcw"},   mod_fcw,      s.mfcw);
         chk_eq({tag, ".mod_shift"}, mod_shift,    s.mshift);
         chk_eq({tag, ".carriers"},  carrier_fcws, s.cf);
         chk_eq({tag, ".note_en"},   note_en,      s.en);
         chk_eq({tag, ".steal"},     voice_steal,  s.stl);
         chk_eq({tag, ".cmd_error"}, cmd_error,    s.err);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      if (!in_ready) chk_eq("ready_wait", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Outputs land on the edge that ends the single EXEC cycle.
   task automatic wait_exec(input string tag);
      int k = 0;
      while (in_ready && k < 4) begin @(posedge clk); #1; k++; end
      chk_eq({tag, ".exec_seen"}, in_ready, 0);
      @(posedge clk); #1;
      cmp_snap(tag);
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] pay, input int nb);
      bit stl = 0;
      send_byte(op);
      for (int i = 0; i < nb; i++) send_byte(pay[8*i +: 8]);
      case (op)
         8'h01: m_mfcw = pay[FW-1:0];
         8'h02: m_ms   = pay[SW-1:0];
         8'h03: m_start(pay[FW-1:0], stl);
         8'h04: for (int v = 0; v < N; v++) if (m_en[v] && m_f[v] == pay[FW-1:0]) m_en[v] = 1'b0;
         8'h05: for (int v = 0; v < N; v++) begin m_en[v] = 1'b0; m_age[v] = 0; end
         default: ;
      endcase
      sb.push_back(m_snap(stl, 1'b0));
      wait_exec(tag);
   endtask

   initial begin
      int k;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst.in_ready", in_ready, 1);
      sb.push_back(m_snap(1'b0, 1'b0));
      cmp_snap("rst");
      @(negedge clk) rst = 1'b0;

      run_cmd("shift8", 8'h02, 32'h08, 1);
      run_cmd("modfcw", 8'h01, 32'h111111, 3);
      run_cmd("start2a", 8'h03, 32'hFF2AAAAA, 3);
      run_cmd("stop2a", 8'h04, 32'h2AAAAA, 3);
      run_cmd("s100", 8'h03, 32'h100, 3);
      run_cmd("s200", 8'h03, 32'h200, 3);
      run_cmd("s300", 8'h03, 32'h300, 3);
      run_cmd("s400", 8'h03, 32'h400, 3);
      run_cmd("retrig", 8'h03, 32'h100, 3);
      run_cmd("steal", 8'h03, 32'h500, 3);
      chk_eq("steal.v1", carrier_fcws[FW +: FW], 24'h000500);
      run_cmd("stop_nomatch", 8'h04, 32'h999, 3);
      run_cmd("alloff", 8'h05, 32'h0, 0);

      send_byte(8'h07);
      chk_eq("badop.in_ready", in_ready, 1);
      sb.push_back(m_snap(1'b0, 1'b1));
      cmp_snap("badop");
      run_cmd("shift3", 8'h02, 32'h03, 1);

      run_cmd("s777", 8'h03, 32'h777, 3);
      send_byte(8'h03);
      send_byte(8'hAA);
      k = 0;
      while (k < 150) begin
         @(posedge clk); #1; k++;
         if (cmd_error) break;
      end
      chk_eq("tmo.cycles", (k >= TO) && (k <= TO + 1), 1);
      sb.push_back(m_snap(1'b0, 1'b1));
      cmp_snap("tmo");
      run_cmd("after_tmo", 8'h03, 32'h123456, 3);

      send_byte(8'h01);
      send_byte(8'h55);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      m_reset();
      chk_eq("rst2.in_ready", in_ready, 1);
      sb.push_back(m_snap(1'b0, 1'b0));
      cmp_snap("rst2");
      @(negedge clk) rst = 1'b0;
      run_cmd("after_rst", 8'h02, 32'h03, 1);

      repeat (3) @(posedge clk);
      #1;
      chk_eq("steal_pulses", n_steal_pulse, 1);
      chk_eq("err_pulses", n_err_pulse, 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
